// File: rtl/clock_ctrl_pkg.sv
// Shared types and default configuration for the CPU clock sequencer.
// No logic: enum state encoding plus default divider and debounce sizes.
// Imported by clock_ctrl and button_conditioner.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        CLK_LOW  = 2'd0,
        CLK_HIGH = 2'd1,
        CLK_HALT = 2'd2
    } clk_state_t;

    localparam int DEF_DIV_WIDTH       = 24;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: 2-flop synchroniser, optional debounce, rising-edge pulse.
// Latency: 3 sys_clk edges from first sample of a press to pulse_o (plus DEBOUNCE_CYCLES with CLK_CTRL_DEBOUNCE_EN).
// No backpressure: pulse_o is a single-cycle strobe, one per accepted press.
module button_conditioner
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_prev_q;
    logic pulse_q;

    // Two-stage synchroniser for the asynchronous raw button.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef CLK_CTRL_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             deb_level_q;
    logic [DEB_W-1:0] deb_cnt_q;

    // Accept a new level only after it has been seen on every one of DEBOUNCE_CYCLES
    // consecutive cycles; any return to the accepted level restarts the count.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
        end else if (sync2_q == deb_level_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_level_q <= sync2_q;
            deb_cnt_q   <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
    end

    assign level = deb_level_q;
`else
    logic unused_deb_cfg;
    assign unused_deb_cfg = (DEBOUNCE_CYCLES > 0);
    assign level          = sync2_q;
`endif

    // Registered rising-edge detector: one pulse per press, nothing while held.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            level_prev_q <= level;
            pulse_q      <= level & ~level_prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/clock_ctrl.sv
// CPU clock sequencer: continuous divider or manual single-step, with HLT stop and resume (debounce via CLK_CTRL_DEBOUNCE_EN).
// Latency: cpu_clk and its rise/fall strobes change on the edge that ends a phase; resume -> cpu_clk=1 next edge.
// No backpressure: steps and resumes outside the states that use them are dropped, never queued.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH       = DEF_DIV_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 step_btn,
    input  logic [DIV_WIDTH-1:0] half_period,
    input  logic                 halt,
    input  logic                 resume,
    output logic                 cpu_clk,
    output logic                 cpu_rise,
    output logic                 cpu_fall,
    output logic                 halted
);

    clk_state_t           state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 cpu_clk_q;
    logic                 rise_q;
    logic                 fall_q;
    logic                 halted_q;
    logic                 step_pls;
    logic                 phase_end;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_btn (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .btn_i   (step_btn),
        .pulse_o (step_pls)
    );

    // >= rather than == so a shrinking half_period cuts the current phase short.
    assign phase_end = (cnt_q >= half_period);

    // Clock FSM with phase counter; outputs and strobes are registered with the state.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLK_LOW;
            cnt_q     <= '0;
            cpu_clk_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                CLK_LOW: begin
                    if (mode ? step_pls : phase_end) begin
                        cnt_q <= '0;
                        if (halt) begin
                            state_q  <= CLK_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q   <= CLK_HIGH;
                            cpu_clk_q <= 1'b1;
                            rise_q    <= 1'b1;
                        end
                    end else if (mode) begin
                        // Manual mode waits with the counter frozen so a later
                        // switch to continuous starts a full low phase.
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                CLK_HIGH: begin
                    // The high phase always completes, whatever mode/halt/step do.
                    if (phase_end) begin
                        state_q   <= CLK_LOW;
                        cnt_q     <= '0;
                        cpu_clk_q <= 1'b0;
                        fall_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                CLK_HALT: begin
                    // Resume forces one rising edge even with halt still high,
                    // giving the CPU a clock to leave HLT.
                    if (resume) begin
                        state_q   <= CLK_HIGH;
                        cnt_q     <= '0;
                        cpu_clk_q <= 1'b1;
                        rise_q    <= 1'b1;
                        halted_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= CLK_LOW;
                    cnt_q     <= '0;
                    cpu_clk_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_clk  = cpu_clk_q;
    assign cpu_rise = rise_q;
    assign cpu_fall = fall_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Testbench for clock_ctrl: scenario tasks with randomized stimulus against an arithmetic waveform model.
// Outputs are sampled on the falling edge; inputs are driven right after sampling.
// Works in both builds; step latency and glitch behaviour follow CLK_CTRL_DEBOUNCE_EN.
module tb_clock_ctrl;

    localparam int DW  = 24;
    localparam int DEB = 8;
`ifdef CLK_CTRL_DEBOUNCE_EN
    localparam int STEP_LAT = 4 + DEB;
`else
    localparam int STEP_LAT = 4;
`endif

    logic          sys_clk;
    logic          rst_n;
    logic          mode;
    logic          step_btn;
    logic [DW-1:0] half_period;
    logic          halt;
    logic          resume;
    logic          cpu_clk;
    logic          cpu_rise;
    logic          cpu_fall;
    logic          halted;

    int total;
    int bad;

    clock_ctrl #(
        .DIV_WIDTH       (DW),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .step_btn    (step_btn),
        .half_period (half_period),
        .halt        (halt),
        .resume      (resume),
        .cpu_clk     (cpu_clk),
        .cpu_rise    (cpu_rise),
        .cpu_fall    (cpu_fall),
        .halted      (halted)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Continuous-mode waveform t edges after a phase restart: {clk, rise, fall}.
    function automatic logic [2:0] cont_exp(input int t, input int hp);
        logic lvl;
        logic bnd;
        lvl = ((t / (hp + 1)) % 2) == 1;
        bnd = (t % (hp + 1)) == 0;
        return {lvl, lvl & bnd, ~lvl & bnd};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic do_reset(input logic m, input int hp, input logic h);
        rst_n       = 1'b0;
        mode        = m;
        half_period = DW'(hp);
        halt        = h;
        resume      = 1'b0;
        step_btn    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 2, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode     = 1'($urandom);
            step_btn = 1'($urandom);
            halt     = 1'($urandom);
            resume   = 1'($urandom);
            tick();
            total++;
            if ({cpu_clk, cpu_rise, cpu_fall, halted} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=0000", i, {cpu_clk, cpu_rise, cpu_fall, halted});
            end
        end
    endtask

    task automatic test_continuous();
        for (int r = 0; r < 5; r++) begin
            int hp;
            hp = (r == 0) ? 2 : (r == 1) ? 0 : int'($urandom_range(1, 7));
            do_reset(1'b0, hp, 1'b0);
            for (int t = 1; t <= 8 * (hp + 1); t++) begin
                // Steps and resumes are meaningless here and must change nothing.
                step_btn = 1'($urandom);
                resume   = 1'($urandom);
                tick();
                total++;
                if ({cpu_clk, cpu_rise, cpu_fall, halted} !== {cont_exp(t, hp), 1'b0}) begin
                    bad++;
                    $display("FAIL continuous hp=%0d t=%0d got=%b want=%b", hp, t,
                             {cpu_clk, cpu_rise, cpu_fall, halted}, {cont_exp(t, hp), 1'b0});
                end
            end
            step_btn = 1'b0;
            resume   = 1'b0;
        end
    endtask

    task automatic test_manual();
        for (int r = 0; r < 2; r++) begin
            int hp;
            hp = (r == 0) ? 4 : int'($urandom_range(0, 6));
            do_reset(1'b1, hp, 1'b0);
            for (int p = 0; p < 2; p++) begin
                int hold, rises, falls, highs, first;
                hold  = (p == 0) ? 100 : int'($urandom_range(30, 80));
                rises = 0; falls = 0; highs = 0; first = -1;
                step_btn = 1'b1;
                for (int c = 1; c <= hold + 60; c++) begin
                    if (c == hold + 1) step_btn = 1'b0;
                    tick();
                    if (cpu_rise) begin
                        rises++;
                        if (first < 0) first = c;
                    end
                    if (cpu_fall) falls++;
                    if (cpu_clk) highs++;
                end
                total++;
                if (first !== STEP_LAT) begin
                    bad++;
                    $display("FAIL manual_latency hp=%0d press=%0d got=%0d want=%0d", hp, p, first, STEP_LAT);
                end
                total++;
                if ({rises, falls, highs} !== {32'd1, 32'd1, 32'(hp + 1)}) begin
                    bad++;
                    $display("FAIL manual_pulse hp=%0d press=%0d rises=%0d falls=%0d highs=%0d want 1/1/%0d",
                             hp, p, rises, falls, highs, hp + 1);
                end
            end
        end
    endtask

    task automatic test_manual_halt();
        int hp, first, highs;
        hp = int'($urandom_range(1, 5));
        first = -1; highs = 0;
        do_reset(1'b1, hp, 1'b1);
        step_btn = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (halted && first < 0) first = c;
            if (cpu_clk) highs++;
        end
        step_btn = 1'b0;
        total++;
        if (first !== STEP_LAT || highs !== 0) begin
            bad++;
            $display("FAIL manual_halt got_halt_at=%0d highs=%0d want %0d/0", first, highs, STEP_LAT);
        end
    endtask

    task automatic test_glitch();
        int rises;
        rises = 0;
        do_reset(1'b1, 2, 1'b0);
`ifdef CLK_CTRL_DEBOUNCE_EN
        for (int g = 1; g < DEB; g++) begin
            step_btn = 1'b1;
            repeat (g) begin tick(); if (cpu_rise) rises++; end
            step_btn = 1'b0;
            repeat (20) begin tick(); if (cpu_rise) rises++; end
        end
        total++;
        if (rises !== 0) begin
            bad++;
            $display("FAIL glitch_rejected got=%0d rises want=0", rises);
        end
        step_btn = 1'b1;
        repeat (DEB + 1) begin tick(); if (cpu_rise) rises++; end
        step_btn = 1'b0;
        repeat (40) begin tick(); if (cpu_rise) rises++; end
`else
        step_btn = 1'b1;
        tick();
        if (cpu_rise) rises++;
        step_btn = 1'b0;
        repeat (30) begin tick(); if (cpu_rise) rises++; end
`endif
        total++;
        if (rises !== 1) begin
            bad++;
            $display("FAIL short_press got=%0d rises want=1", rises);
        end
    endtask

    task automatic test_halt();
        int hp, n, highs;
        hp = int'($urandom_range(1, 4));
        do_reset(1'b0, hp, 1'b1);
        for (int t = 1; t <= hp + 1; t++) begin
            tick();
            total++;
            if ({halted, cpu_clk} !== {(t == hp + 1), 1'b0}) begin
                bad++;
                $display("FAIL halt_entry t=%0d got=%b want=%b", t, {halted, cpu_clk}, {(t == hp + 1), 1'b0});
            end
        end
        n = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (!halted || cpu_clk || cpu_rise) n++;
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL halt_hold got=%0d bad cycles want=0", n);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        total++;
        if ({cpu_clk, cpu_rise, halted} !== 3'b110) begin
            bad++;
            $display("FAIL resume_edge got=%b want=110", {cpu_clk, cpu_rise, halted});
        end
        n = 0; highs = 1;
        while (!halted && n < 100) begin
            tick();
            n++;
            if (cpu_clk) highs++;
        end
        total++;
        if (n !== 2 * (hp + 1) || highs !== hp + 1) begin
            bad++;
            $display("FAIL halt_reentry got=%0d cycles/%0d high want=%0d/%0d", n, highs, 2 * (hp + 1), hp + 1);
        end
    endtask

    task automatic test_shrink();
        do_reset(1'b0, 10, 1'b0);
        repeat (16) tick();
        total++;
        if (cpu_clk !== 1'b1) begin
            bad++;
            $display("FAIL shrink_pre got=%b want=1", cpu_clk);
        end
        half_period = DW'(1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if ({cpu_clk, cpu_rise, cpu_fall} !== cont_exp(k - 1, 1)) begin
                bad++;
                $display("FAIL shrink k=%0d got=%b want=%b", k, {cpu_clk, cpu_rise, cpu_fall}, cont_exp(k - 1, 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        int hp;
        hp = int'($urandom_range(3, 6));
        do_reset(1'b0, hp, 1'b0);
        repeat (hp + 2) tick();
        total++;
        if (cpu_clk !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre got=%b want=1", cpu_clk);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cpu_clk, cpu_rise, cpu_fall, halted} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid_high got=%b want=0000", {cpu_clk, cpu_rise, cpu_fall, halted});
        end
        do_reset(1'b0, hp, 1'b1);
        repeat (hp + 3) tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_halt got=%b want=0", halted);
        end
        @(negedge sys_clk);
        halt  = 1'b0;
        rst_n = 1'b1;
        for (int t = 1; t <= 2 * (hp + 1); t++) begin
            tick();
            total++;
            if ({cpu_clk, cpu_rise, cpu_fall} !== cont_exp(t, hp)) begin
                bad++;
                $display("FAIL rst_restart t=%0d got=%b want=%b", t, {cpu_clk, cpu_rise, cpu_fall}, cont_exp(t, hp));
            end
        end
    endtask

    task automatic test_mode_switch();
        int hp, n;
        hp = int'($urandom_range(1, 5));
        do_reset(1'b1, hp, 1'b0);
        n = 0;
        repeat (10) begin tick(); if (cpu_clk) n++; end
        mode = 1'b0;
        for (int t = 1; t <= 2 * (hp + 1); t++) begin
            tick();
            total++;
            if ({cpu_clk, cpu_rise, cpu_fall} !== cont_exp(t, hp)) begin
                bad++;
                $display("FAIL man_to_cont t=%0d got=%b want=%b", t, {cpu_clk, cpu_rise, cpu_fall}, cont_exp(t, hp));
            end
        end
        mode = 1'b1;
        repeat (40) begin tick(); if (cpu_clk || cpu_rise) n++; end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL cont_to_man got=%0d high cycles want=0", n);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_continuous();
        test_manual();
        test_manual_halt();
        test_glitch();
        test_halt();
        test_shrink();
        test_reset_mid();
        test_mode_switch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
